// File: rtl/clk_en_controller_pkg.sv
// Shared state encodings and widths for the clk_en_controller block.
package ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStep  = 2'b01,
    StRun   = 2'b10,
    StBurst = 2'b11
  } state_e;

  localparam int unsigned EN_COUNT_WIDTH = 8;

endpackage

// File: rtl/clk_en_controller_tick_gen.sv
// Prescaler for clk_en_controller: latches the divisor on entry and raises tick every div+1 cycles.
module tick_gen #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;

  assign tick = (cnt_q == div_q);

  // load has priority so an entry always starts from a freshly latched divisor
  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (load) begin
      div_d = div;
      cnt_d = '0;
    end else if (clear) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/clk_en_controller.sv
// Datapath clock-enable scheduler: single-step, prescaled run and counted burst modes.
// Define CLK_EN_COUNT_EN to build the en_count pulse counter; otherwise en_count is tied to 0.
module clk_en_controller
  import ctrl_pkg::*;
#(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      step_p,
  input  logic                      run_p,
  input  logic                      burst_p,
  input  logic                      halt,
  input  logic [DIV_WIDTH-1:0]      div,
  input  logic [BURST_WIDTH-1:0]    burst_len,
  output logic                      clk_en,
  output logic                      busy,
  output logic [1:0]                mode,
  output logic [EN_COUNT_WIDTH-1:0] en_count
);

  state_e                 state_q, state_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic                   busy_q;
  logic                   tick;
  logic                   tg_load, tg_clear, tg_advance;

  tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (tg_load),
    .clear  (tg_clear),
    .advance(tg_advance),
    .div    (div),
    .tick   (tick)
  );

  // halt masks the strobe combinationally, even before the FSM leaves its state
  assign clk_en = ~halt & ((state_q == StStep) |
                           (((state_q == StRun) | (state_q == StBurst)) & tick));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tg_load    = 1'b0;
    tg_clear   = 1'b0;
    tg_advance = 1'b0;
    if (halt) begin
      state_d  = StIdle;
      tg_clear = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (run_p) begin
            state_d = StRun;
            tg_load = 1'b1;
          end else if (burst_p && (burst_len != '0)) begin
            state_d = StBurst;
            tg_load = 1'b1;
            rem_d   = burst_len;
          end else if (step_p) begin
            state_d = StStep;
          end
        end
        StStep: begin
          state_d = StIdle;
        end
        StRun: begin
          if (run_p) begin
            state_d = StIdle;
          end else begin
            tg_advance = 1'b1;
          end
        end
        StBurst: begin
          if (run_p) begin
            state_d = StIdle;
          end else begin
            tg_advance = 1'b1;
            if (tick) begin
              rem_d = rem_q - BURST_WIDTH'(1);
              if (rem_q == BURST_WIDTH'(1)) begin
                state_d = StIdle;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign mode = state_q;
  assign busy = busy_q;

`ifdef CLK_EN_COUNT_EN
  logic [EN_COUNT_WIDTH-1:0] en_count_q, en_count_d;

  assign en_count_d = en_count_q + EN_COUNT_WIDTH'(clk_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_count_q <= '0;
    end else begin
      en_count_q <= en_count_d;
    end
  end

  assign en_count = en_count_q;
`else
  assign en_count = '0;
`endif

endmodule
